pilha_param: RTL and testbench
==============================

# pilha_param

Parametrised return-address stack for the multicycle processor; successor to the fixed call stack that feeds the PC mux on return.
- Generalised in data width and depth.
- Exposes level, full/empty and error status.
- Defines behaviour for simultaneous push/pop.
- Offers a selectable overflow policy: reject, or circular overwrite of the oldest entry.
- Sits between `registradorPC` output (push data) and the PC source mux (top-of-stack input).
- Driven by the `push`/`pop` strobes of the control unit.

## Interface
- `WIDTH`, 32: data/entry width in bits.
- `DEPTH`, 16: number of entries; any integer ≥ 2 (not restricted to a power of two).
- `CIRCULAR`, 0: overflow policy. 0 = reject push when full. 1 = discard oldest entry and accept.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `push` in 1: push `dado` this cycle.
- `pop` in 1: remove top entry this cycle.
- `dado` in WIDTH: value to push (return address).
- `clr_erro` in 1: clears sticky `erro`.
- `saida` out WIDTH: current top entry, registered; 0 when empty.
- `vazia` out 1: level == 0.
- `cheia` out 1: level == DEPTH.
- `nivel` out $clog2(DEPTH+1): number of valid entries.
- `erro` out 1: sticky; set on rejected push or on pop when empty.
- `descarte` out 1: one-cycle pulse; oldest entry dropped (CIRCULAR=1 only).

## Operation
- **Storage:** DEPTH-entry register array plus a top pointer and a level counter.
  - CIRCULAR=1: the pointer wraps modulo DEPTH (ring buffer).
  - CIRCULAR=0: the pointer never wraps.
- **Read model:** `saida` always shows the top entry. The consumer reads `saida` in the same cycle it asserts `pop`. The pop then exposes the next entry after the edge.
- **Push only, not full:** write `dado` at top+1; level +1; `saida` ← `dado`.
- **Push only, full, CIRCULAR=0:** no change to storage, level or `saida`; `erro` ← 1.
- **Push only, full, CIRCULAR=1:** overwrite the oldest slot (pointer wraps); level stays DEPTH; `saida` ← `dado`; `descarte` pulses 1 cycle; `erro` unchanged.
- **Pop only, not empty:** level −1; `saida` ← entry below top, or 0 if the level becomes 0.
- **Pop only, empty:** no change; `erro` ← 1; `saida` stays 0.
- **Push and pop together, level ≥ 1:** replace the top with `dado`; level unchanged; `saida` ← `dado`. Never an error, even when full.
- **Push and pop together, empty:** treated as push only; `erro` unchanged.
- **Error clear:**
  - `clr_erro`=1 clears `erro` at the edge.
  - If an error event occurs in the same cycle, set wins and `erro`=1.
- **Reset (rst=0 at an edge):**
  - level=0, pointer=0, `saida`=0, `erro`=0, `descarte`=0.
  - `vazia`=1, `cheia`=0.
  - Array contents need not be cleared and are never visible.
  - Reset dominates any concurrent push/pop.

## Timing
- Every output is registered, or is a direct function of registered state (`vazia`, `cheia`, `nivel`).
- There is no combinational path from inputs to outputs.
- Push latency: `dado` pushed at edge n appears on `saida` immediately after edge n. Zero extra cycles.
- Back-to-back push/pop is allowed every cycle. There is no handshake or stall; strobes are one-cycle qualified.
- Reset mid-operation: the next edge with rst=0 empties the stack regardless of level. Pushes resume on the first edge with rst=1.
- `descarte` is high exactly for the cycle following the overwriting edge.

## Test plan
- **Reset then fill (DEPTH=4, CIRCULAR=0):**
  - Stimulus: push 0x10, 0x20, 0x30, 0x40.
  - Response: `nivel` 1..4; `saida` follows each value; `cheia`=1 after the 4th push; `erro`=0.
- **Overflow reject:**
  - Stimulus: full (DEPTH=4, CIRCULAR=0), push 0x50.
  - Response: `saida`=0x40, `nivel`=4, `erro`=1. Four pops then read 0x40, 0x30, 0x20, 0x10; `saida`=0 and `vazia`=1 after the last pop.
- **Circular overwrite:**
  - Stimulus: DEPTH=4, CIRCULAR=1; push 1..6.
  - Response: `descarte` pulses after the 5th and 6th pushes; `nivel`=4. Pops yield 6, 5, 4, 3, then `vazia`=1; `erro`=0 throughout.
- **Underflow and clear:**
  - Stimulus: empty, pop.
  - Response: `erro`=1, `nivel`=0, `saida`=0.
  - Then `clr_erro` alone gives `erro`=0. `clr_erro` together with another empty pop gives `erro`=1.
- **Simultaneous push/pop:**
  - Stack [0xA, 0xB] with 0xB on top; push+pop with `dado`=0xC gives `saida`=0xC, `nivel`=2. A following pop gives `saida`=0xA.
  - Push+pop on an empty stack with `dado`=0x7 gives `nivel`=1, `saida`=0x7.
- **Reset mid-operation:**
  - Stimulus: `nivel`=3; assert rst=0 for 1 edge while push=1.
  - Response: `nivel`=0, `saida`=0, `erro`=0. A push of 0x99 on the next edge gives `nivel`=1, `saida`=0x99.

Source files
------------

// File: rtl/pilha_param.sv
// pilha_param: parametrised return-address stack.
//
// Holds up to DEPTH return addresses of WIDTH bits. The top entry is always
// visible on saida (registered, 0 when empty), so a consumer reads saida in
// the same cycle it pulses pop. Push and pop together replace the top entry.
// With CIRCULAR=1 a push into a full stack overwrites the oldest entry and
// pulses descarte. Otherwise the push is rejected and sets the sticky erro.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous reset, active low
//   push     - push dado this cycle
//   pop      - remove top entry this cycle
//   dado     - value to push
//   clr_erro - clears sticky erro (a concurrent error event wins)
//   saida    - registered top entry, 0 when empty
//   vazia    - stack empty
//   cheia    - stack full
//   nivel    - number of valid entries
//   erro     - sticky: rejected push or pop on empty
//   descarte - one-cycle pulse after the oldest entry was overwritten
module pilha_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter bit CIRCULAR = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           dado,
  input  logic                       clr_erro,
  output logic [WIDTH-1:0]           saida,
  output logic                       vazia,
  output logic                       cheia,
  output logic [$clog2(DEPTH+1)-1:0] nivel,
  output logic                       erro,
  output logic                       descarte
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // ptr is the next free slot. In reject mode it counts 0..DEPTH and never
  // wraps. In circular mode it wraps modulo DEPTH, so when the ring is full
  // it also addresses the oldest entry, which is the slot to overwrite.
  logic [LW-1:0]    ptr, ptrNxt;
  logic [LW-1:0]    level, levelNxt;
  logic [WIDTH-1:0] saidaNxt;
  logic [LW-1:0]    topIdx, belowIdx, wrIdx;
  logic             wrEn, errEvt, descNxt;
  logic             isEmpty, isFull;

  function automatic logic [LW-1:0] ptrInc(input logic [LW-1:0] p);
    if (CIRCULAR && p == LW'(DEPTH - 1)) return '0;
    return p + LW'(1);
  endfunction

  // Only reached at p==0 in circular mode; in reject mode ptr==level>=1
  // whenever a decrement is used.
  function automatic logic [LW-1:0] ptrDec(input logic [LW-1:0] p);
    if (p == '0) return LW'(DEPTH - 1);
    return p - LW'(1);
  endfunction

  assign isEmpty  = (level == '0);
  assign isFull   = (level == LW'(DEPTH));
  assign topIdx   = ptrDec(ptr);
  assign belowIdx = ptrDec(topIdx);

  always_comb begin
    wrEn     = 1'b0;
    wrIdx    = ptr;
    ptrNxt   = ptr;
    levelNxt = level;
    saidaNxt = saida;
    errEvt   = 1'b0;
    descNxt  = 1'b0;
    if (push && pop && !isEmpty) begin
      // Replace the top in place; legal even when full.
      wrEn     = 1'b1;
      wrIdx    = topIdx;
      saidaNxt = dado;
    end else if (push) begin
      // Also covers push+pop on an empty stack.
      if (!isFull) begin
        wrEn     = 1'b1;
        ptrNxt   = ptrInc(ptr);
        levelNxt = level + LW'(1);
        saidaNxt = dado;
      end else if (CIRCULAR) begin
        wrEn     = 1'b1;
        ptrNxt   = ptrInc(ptr);
        saidaNxt = dado;
        descNxt  = 1'b1;
      end else begin
        errEvt = 1'b1;
      end
    end else if (pop) begin
      if (!isEmpty) begin
        ptrNxt   = topIdx;
        levelNxt = level - LW'(1);
        saidaNxt = (level >= LW'(2)) ? mem[AW'(belowIdx)] : '0;
      end else begin
        errEvt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      level    <= '0;
      saida    <= '0;
      erro     <= 1'b0;
      descarte <= 1'b0;
    end else begin
      ptr      <= ptrNxt;
      level    <= levelNxt;
      saida    <= saidaNxt;
      erro     <= errEvt | (erro & ~clr_erro);
      descarte <= descNxt;
    end
  end

  // Storage is never reset; entries above the level are never exposed.
  always_ff @(posedge clk) begin
    if (rst && wrEn) mem[AW'(wrIdx)] <= dado;
  end

  assign vazia = isEmpty;
  assign cheia = isFull;
  assign nivel = level;

endmodule

// File: tb/tb_pilha_param.sv
// Bench for pilha_param: a reject-mode and a circular-mode instance (DEPTH=4)
// share one stimulus stream and are compared every cycle against a simple
// array-based stack model, with literal expectations on the directed cases.
module tb_pilha_param;

  localparam int W = 16;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst, push, pop, clr_erro;
  logic [W-1:0] dado;

  logic [W-1:0] saidaW [2];
  logic         vaziaW [2];
  logic         cheiaW [2];
  logic [2:0]   nivelW [2];
  logic         erroW  [2];
  logic         descW  [2];

  int checks = 0;
  int errors = 0;

  // Model: stk[m][0] is the bottom, stk[m][cnt-1] the top.
  logic [W-1:0] stk [2][D];
  int           cnt [2];
  bit           mErr [2];
  bit           mDesc [2];

  always #5 clk = ~clk;

  pilha_param #(.WIDTH(W), .DEPTH(D), .CIRCULAR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dado(dado),
    .clr_erro(clr_erro), .saida(saidaW[0]), .vazia(vaziaW[0]),
    .cheia(cheiaW[0]), .nivel(nivelW[0]), .erro(erroW[0]),
    .descarte(descW[0]));

  pilha_param #(.WIDTH(W), .DEPTH(D), .CIRCULAR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dado(dado),
    .clr_erro(clr_erro), .saida(saidaW[1]), .vazia(vaziaW[1]),
    .cheia(cheiaW[1]), .nivel(nivelW[1]), .erro(erroW[1]),
    .descarte(descW[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic modelStep();
    bit evt;
    for (int m = 0; m < 2; m++) begin
      if (!rst) begin
        cnt[m] = 0; mErr[m] = 0; mDesc[m] = 0;
      end else begin
        evt = 0;
        mDesc[m] = 0;
        if (push && pop) begin
          if (cnt[m] > 0) stk[m][cnt[m]-1] = dado;
          else begin stk[m][0] = dado; cnt[m] = 1; end
        end else if (push) begin
          if (cnt[m] < D) begin
            stk[m][cnt[m]] = dado; cnt[m]++;
          end else if (m == 1) begin
            for (int i = 0; i < D - 1; i++) stk[m][i] = stk[m][i+1];
            stk[m][D-1] = dado;
            mDesc[m] = 1;
          end else evt = 1;
        end else if (pop) begin
          if (cnt[m] > 0) cnt[m]--;
          else evt = 1;
        end
        mErr[m] = evt | (mErr[m] & !clr_erro);
      end
    end
  endtask

  task automatic compareAll();
    logic [W-1:0] es;
    for (int m = 0; m < 2; m++) begin
      es = (cnt[m] > 0) ? stk[m][cnt[m]-1] : '0;
      chk($sformatf("m%0d saida", m), saidaW[m], es);
      chk($sformatf("m%0d nivel", m), nivelW[m], cnt[m]);
      chk($sformatf("m%0d vazia", m), vaziaW[m], cnt[m] == 0);
      chk($sformatf("m%0d cheia", m), cheiaW[m], cnt[m] == D);
      chk($sformatf("m%0d erro", m), erroW[m], mErr[m]);
      chk($sformatf("m%0d descarte", m), descW[m], mDesc[m]);
    end
  endtask

  // One clock: drive inputs, advance the model with them, then compare
  // on the falling edge after the rising edge.
  task automatic cyc(input logic pu, input logic po, input logic [W-1:0] d,
                     input logic cl, input logic rs);
    push = pu; pop = po; dado = d; clr_erro = cl; rst = rs;
    modelStep();
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    logic [W-1:0] fillV [4];
    fillV[0] = 16'h10; fillV[1] = 16'h20; fillV[2] = 16'h30; fillV[3] = 16'h40;
    rst = 1'b0; push = 1'b0; pop = 1'b0; dado = '0; clr_erro = 1'b0;

    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("reset saida", saidaW[0], 0);
    chk("reset vazia", vaziaW[0], 1);
    chk("reset nivel", nivelW[0], 0);

    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, fillV[i], 0, 1);
      chk("fill nivel", nivelW[0], i + 1);
      chk("fill saida", saidaW[0], fillV[i]);
    end
    chk("fill cheia", cheiaW[0], 1);
    chk("fill erro", erroW[0], 0);

    cyc(1, 0, 16'h50, 0, 1);
    chk("ovf saida", saidaW[0], 16'h40);
    chk("ovf nivel", nivelW[0], 4);
    chk("ovf erro", erroW[0], 1);
    chk("circ ovf saida", saidaW[1], 16'h50);
    chk("circ ovf descarte", descW[1], 1);
    chk("circ ovf erro", erroW[1], 0);

    for (int i = 0; i < 4; i++) begin
      chk("pop read", saidaW[0], fillV[3-i]);
      chk("circ pop read", saidaW[1], 16'h50 - 16'(16 * i));
      cyc(0, 1, 0, 0, 1);
    end
    chk("drain saida", saidaW[0], 0);
    chk("drain vazia", vaziaW[0], 1);

    cyc(0, 0, 0, 1, 1);
    chk("clr erro", erroW[0], 0);

    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0, 16'(i), 0, 1);
      chk("circ descarte", descW[1], i >= 5);
    end
    chk("circ nivel", nivelW[1], 4);
    for (int k = 0; k < 4; k++) begin
      chk("circ pop order", saidaW[1], 6 - k);
      cyc(0, 1, 0, 0, 1);
    end
    chk("circ vazia", vaziaW[1], 1);
    chk("circ erro", erroW[1], 0);
    cyc(0, 0, 0, 1, 1);

    cyc(0, 1, 0, 0, 1);
    chk("udf erro", erroW[0], 1);
    chk("udf nivel", nivelW[0], 0);
    chk("udf saida", saidaW[0], 0);
    cyc(0, 0, 0, 1, 1);
    chk("clr alone", erroW[0], 0);
    cyc(0, 1, 0, 1, 1);
    chk("clr vs set", erroW[0], 1);
    cyc(0, 0, 0, 1, 1);

    cyc(1, 0, 16'hA, 0, 1);
    cyc(1, 0, 16'hB, 0, 1);
    cyc(1, 1, 16'hC, 0, 1);
    chk("pp saida", saidaW[0], 16'hC);
    chk("pp nivel", nivelW[0], 2);
    cyc(0, 1, 0, 0, 1);
    chk("pp pop", saidaW[0], 16'hA);
    cyc(0, 1, 0, 0, 1);
    cyc(1, 1, 16'h7, 0, 1);
    chk("pp empty nivel", nivelW[0], 1);
    chk("pp empty saida", saidaW[0], 16'h7);
    chk("pp empty erro", erroW[0], 0);

    cyc(1, 0, 16'h21, 0, 1);
    cyc(1, 0, 16'h22, 0, 1);
    chk("mid nivel", nivelW[0], 3);
    cyc(1, 0, 16'h55, 0, 0);
    chk("mid rst nivel", nivelW[0], 0);
    chk("mid rst saida", saidaW[0], 0);
    chk("mid rst erro", erroW[0], 0);
    cyc(1, 0, 16'h99, 0, 1);
    chk("after rst nivel", nivelW[0], 1);
    chk("after rst saida", saidaW[0], 16'h99);

    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), 1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 63) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
